// File: rtl/id_pipe.sv
// rtl/id_pipe.sv - MIPS decode stage: logic/LUI/LW decode, operand forwarding,
// load-use stall and a registered ID/EX stage with valid/ready handshake.
module id_pipe #(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int NUM_FWD = 2,
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush_i,
  input  logic                      if_valid_i,
  output logic                      id_ready_o,
  input  logic [31:0]               pc_i,
  input  logic [31:0]               inst_i,
  output logic                      reg1_read_o,
  output logic                      reg2_read_o,
  output logic [REG_AW-1:0]         reg1_addr_o,
  output logic [REG_AW-1:0]         reg2_addr_o,
  input  logic [DATA_W-1:0]         reg1_data_i,
  input  logic [DATA_W-1:0]         reg2_data_i,
  input  logic [NUM_FWD-1:0]        fwd_we_i,
  input  logic [NUM_FWD-1:0]        fwd_is_load_i,
  input  logic [NUM_FWD*REG_AW-1:0] fwd_addr_i,
  input  logic [NUM_FWD*DATA_W-1:0] fwd_data_i,
  input  logic                      ex_ready_i,
  output logic                      id_valid_o,
  output logic [7:0]                aluop_o,
  output logic [2:0]                alusel_o,
  output logic [DATA_W-1:0]         reg1_o,
  output logic [DATA_W-1:0]         reg2_o,
  output logic [REG_AW-1:0]         wd_o,
  output logic                      wreg_o,
  output logic [31:0]               pc_o,
  output logic                      inst_err_o,
  output logic [CNT_W-1:0]          stall_cnt_o
);

  logic [5:0]  op, funct;
  logic [4:0]  sa;
  logic [15:0] imm;

  assign op    = inst_i[31:26];
  assign sa    = inst_i[10:6];
  assign funct = inst_i[5:0];
  assign imm   = inst_i[15:0];

  assign reg1_addr_o = REG_AW'(inst_i[25:21]);
  assign reg2_addr_o = REG_AW'(inst_i[20:16]);

  logic [7:0]        dec_aluop;
  logic [2:0]        dec_alusel;
  logic [REG_AW-1:0] dec_wd;
  logic              dec_wreg;
  logic              dec_err;
  logic [DATA_W-1:0] dec_imm;

  always_comb begin
    dec_aluop   = '0;
    dec_alusel  = '0;
    dec_wd      = '0;
    dec_wreg    = 1'b0;
    dec_err     = 1'b0;
    dec_imm     = '0;
    reg1_read_o = 1'b0;
    reg2_read_o = 1'b0;
    case (op)
      6'h00: begin
        if (sa == 5'd0 && funct >= 6'h24 && funct <= 6'h27) begin
          dec_aluop   = {2'b00, funct};
          dec_alusel  = 3'b001;
          dec_wd      = REG_AW'(inst_i[15:11]);
          dec_wreg    = 1'b1;
          reg1_read_o = 1'b1;
          reg2_read_o = 1'b1;
        end else begin
          dec_err = 1'b1;
        end
      end
      6'h0C, 6'h0D, 6'h0E: begin
        dec_aluop   = 8'h24 + {6'd0, op[1:0]};
        dec_alusel  = 3'b001;
        dec_wd      = reg2_addr_o;
        dec_wreg    = 1'b1;
        dec_imm     = {{(DATA_W-16){1'b0}}, imm};
        reg1_read_o = 1'b1;
      end
      6'h0F: begin
        dec_aluop  = 8'h25;
        dec_alusel = 3'b001;
        dec_wd     = reg2_addr_o;
        dec_wreg   = 1'b1;
        dec_imm    = {{(DATA_W-32){1'b0}}, imm, 16'h0000};
      end
      6'h23: begin
        dec_aluop   = 8'hE3;
        dec_alusel  = 3'b111;
        dec_wd      = reg2_addr_o;
        dec_wreg    = 1'b1;
        dec_imm     = {{(DATA_W-16){imm[15]}}, imm};
        reg1_read_o = 1'b1;
      end
      default: dec_err = 1'b1;
    endcase
  end

  // Scan oldest to youngest so the lowest matching index overrides.
  logic [DATA_W-1:0] src1_data, src2_data;
  logic              src1_load, src2_load;

  always_comb begin
    src1_data = reg1_data_i;
    src1_load = 1'b0;
    src2_data = reg2_data_i;
    src2_load = 1'b0;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (fwd_we_i[i] && fwd_addr_i[i*REG_AW +: REG_AW] == reg1_addr_o) begin
        src1_data = fwd_data_i[i*DATA_W +: DATA_W];
        src1_load = fwd_is_load_i[i];
      end
      if (fwd_we_i[i] && fwd_addr_i[i*REG_AW +: REG_AW] == reg2_addr_o) begin
        src2_data = fwd_data_i[i*DATA_W +: DATA_W];
        src2_load = fwd_is_load_i[i];
      end
    end
    if (reg1_addr_o == '0) begin
      src1_data = '0;
      src1_load = 1'b0;
    end
    if (reg2_addr_o == '0) begin
      src2_data = '0;
      src2_load = 1'b0;
    end
  end

  logic hazard, advance, take;

  assign hazard     = if_valid_i & ((reg1_read_o & src1_load) | (reg2_read_o & src2_load));
  assign advance    = !id_valid_o | ex_ready_i;
  assign take       = if_valid_i & !hazard;
  assign id_ready_o = flush_i | (!hazard & advance);

  always_ff @(posedge clk) begin
    if (rst || flush_i || (advance && !take)) begin
      id_valid_o <= 1'b0;
      aluop_o    <= '0;
      alusel_o   <= '0;
      reg1_o     <= '0;
      reg2_o     <= '0;
      wd_o       <= '0;
      wreg_o     <= 1'b0;
      pc_o       <= '0;
      inst_err_o <= 1'b0;
    end else if (advance) begin
      id_valid_o <= 1'b1;
      aluop_o    <= dec_aluop;
      alusel_o   <= dec_alusel;
      reg1_o     <= reg1_read_o ? src1_data : '0;
      reg2_o     <= reg2_read_o ? src2_data : dec_imm;
      wd_o       <= dec_wd;
      wreg_o     <= dec_wreg;
      pc_o       <= pc_i;
      inst_err_o <= dec_err;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_o <= '0;
    end else if (hazard && !flush_i && stall_cnt_o != '1) begin
      stall_cnt_o <= stall_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_id_pipe.sv
// tb/tb_id_pipe.sv - self-checking bench for id_pipe: vector table, corner
// sequences and randomized traffic against a behavioural model.
module tb_id_pipe;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NF = 2;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst, flush, if_valid, ex_ready;
  logic [31:0] pc, inst;
  logic [DW-1:0] rd1, rd2;
  logic [NF-1:0] fwe, fld;
  logic [AW-1:0] fa[NF];
  logic [DW-1:0] fd[NF];
  logic [NF*AW-1:0] fa_p;
  logic [NF*DW-1:0] fd_p;

  logic id_ready, reg1_read, reg2_read, id_valid, wreg, inst_err;
  logic [AW-1:0] reg1_addr, reg2_addr, wd;
  logic [7:0] aluop;
  logic [2:0] alusel;
  logic [DW-1:0] reg1, reg2;
  logic [31:0] pc_out;
  logic [CW-1:0] stall_cnt;

  always_comb begin
    fa_p = '0;
    fd_p = '0;
    for (int i = 0; i < NF; i++) begin
      fa_p[i*AW +: AW] = fa[i];
      fd_p[i*DW +: DW] = fd[i];
    end
  end

  id_pipe #(.DATA_W(DW), .REG_AW(AW), .NUM_FWD(NF), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .flush_i(flush), .if_valid_i(if_valid), .id_ready_o(id_ready),
    .pc_i(pc), .inst_i(inst), .reg1_read_o(reg1_read), .reg2_read_o(reg2_read),
    .reg1_addr_o(reg1_addr), .reg2_addr_o(reg2_addr), .reg1_data_i(rd1), .reg2_data_i(rd2),
    .fwd_we_i(fwe), .fwd_is_load_i(fld), .fwd_addr_i(fa_p), .fwd_data_i(fd_p),
    .ex_ready_i(ex_ready), .id_valid_o(id_valid), .aluop_o(aluop), .alusel_o(alusel),
    .reg1_o(reg1), .reg2_o(reg2), .wd_o(wd), .wreg_o(wreg), .pc_o(pc_out),
    .inst_err_o(inst_err), .stall_cnt_o(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          v;
    logic [7:0]    aluop;
    logic [2:0]    alusel;
    logic [DW-1:0] r1;
    logic [DW-1:0] r2;
    logic [AW-1:0] wd;
    logic          wreg;
    logic [31:0]   pc;
    logic          err;
  } st_t;

  st_t m;
  logic [CW-1:0] mcnt;
  logic last_ready;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // First writing source with a matching address wins; register 0 is hardwired.
  function automatic logic [DW-1:0] resolve(input logic [AW-1:0] a, input logic [DW-1:0] rf,
                                            output logic is_ld);
    is_ld = 1'b0;
    if (a == 0) return '0;
    for (int i = 0; i < NF; i++)
      if (fwe[i] && fa[i] == a) begin
        is_ld = fld[i];
        return fd[i];
      end
    return rf;
  endfunction

  function automatic st_t model_decode(input logic [31:0] w, output logic haz,
                                       output logic u1, output logic u2);
    st_t d;
    logic l1, l2;
    logic [DW-1:0] s1, s2;
    logic [5:0] op, fn;
    op = w[31:26];
    fn = w[5:0];
    d = '0;
    d.v = 1'b1;
    d.pc = pc;
    s1 = resolve(w[25:21], rd1, l1);
    s2 = resolve(w[20:16], rd2, l2);
    u1 = 0; u2 = 0;
    if (op == 0 && w[10:6] == 0 && fn inside {6'h24, 6'h25, 6'h26, 6'h27}) begin
      d.aluop = {2'b00, fn}; d.alusel = 3'b001; d.r1 = s1; d.r2 = s2;
      d.wd = w[15:11]; d.wreg = 1; u1 = 1; u2 = 1;
    end else if (op inside {6'h0C, 6'h0D, 6'h0E}) begin
      d.aluop = 8'h24 + 8'(op - 6'h0C); d.alusel = 3'b001; d.r1 = s1;
      d.r2 = {16'h0, w[15:0]}; d.wd = w[20:16]; d.wreg = 1; u1 = 1;
    end else if (op == 6'h0F) begin
      d.aluop = 8'h25; d.alusel = 3'b001; d.r2 = {w[15:0], 16'h0};
      d.wd = w[20:16]; d.wreg = 1;
    end else if (op == 6'h23) begin
      d.aluop = 8'hE3; d.alusel = 3'b111; d.r1 = s1;
      d.r2 = {{16{w[15]}}, w[15:0]}; d.wd = w[20:16]; d.wreg = 1; u1 = 1;
    end else begin
      d.err = 1;
    end
    haz = if_valid && ((u1 && l1) || (u2 && l2));
    return d;
  endfunction

  task automatic check_regs();
    chk("id_valid", id_valid, m.v);
    chk("aluop", aluop, m.aluop);
    chk("alusel", alusel, m.alusel);
    chk("reg1", reg1, m.r1);
    chk("reg2", reg2, m.r2);
    chk("wd", wd, m.wd);
    chk("wreg", wreg, m.wreg);
    chk("pc", pc_out, m.pc);
    chk("inst_err", inst_err, m.err);
    chk("stall_cnt", stall_cnt, mcnt);
  endtask

  // One clock: check combinational outputs, advance the model, check registers.
  task automatic cycle();
    st_t d;
    logic h, u1, u2;
    #1;
    d = model_decode(inst, h, u1, u2);
    last_ready = id_ready;
    chk("id_ready", id_ready, flush | (!h & (!m.v | ex_ready)));
    chk("reg1_read", reg1_read, u1);
    chk("reg2_read", reg2_read, u2);
    chk("reg1_addr", reg1_addr, inst[25:21]);
    chk("reg2_addr", reg2_addr, inst[20:16]);
    @(posedge clk);
    if (rst) mcnt = '0;
    else if (h && !flush && mcnt != '1) mcnt = mcnt + 1'b1;
    if (rst || flush) m = '0;
    else if (!m.v || ex_ready) m = (if_valid && !h) ? d : '0;
    #1;
    check_regs();
  endtask

  task automatic clear_fwd();
    fwe = '0; fld = '0;
    for (int i = 0; i < NF; i++) begin fa[i] = '0; fd[i] = '0; end
  endtask

  typedef struct {
    logic [31:0] inst, d1, d2;
    logic [1:0]  we, ld;
    logic [4:0]  a0, a1;
    logic [31:0] f0, f1;
    logic [7:0]  aluop;
    logic [2:0]  alusel;
    logic [31:0] e1, e2;
    logic [4:0]  wd;
    logic        wreg, err;
  } vec_t;

  vec_t vt[10];
  st_t saved;
  logic [CW-1:0] cnt0;

  initial begin
    vt[0] = '{32'h342200FF, 32'h12340000, 0, 2'b00, 2'b00, 0, 0, 0, 0, 8'h25, 3'b001, 32'h12340000, 32'h000000FF, 2, 1, 0};
    vt[1] = '{32'h00221824, 0, 32'hCCCC, 2'b11, 2'b00, 1, 1, 32'hAAAA, 32'hBBBB, 8'h24, 3'b001, 32'hAAAA, 32'hCCCC, 3, 1, 0};
    vt[2] = '{32'h00221824, 0, 0, 2'b11, 2'b00, 1, 2, 32'hAAAA, 32'hCCCC, 8'h24, 3'b001, 32'hAAAA, 32'hCCCC, 3, 1, 0};
    vt[3] = '{32'h00021824, 32'h9999, 0, 2'b11, 2'b00, 0, 2, 32'h1111, 32'hCCCC, 8'h24, 3'b001, 0, 32'hCCCC, 3, 1, 0};
    vt[4] = '{32'h3C071234, 32'h5555, 0, 2'b00, 2'b00, 0, 0, 0, 0, 8'h25, 3'b001, 0, 32'h12340000, 7, 1, 0};
    vt[5] = '{32'h8D28FFFC, 32'h1000, 0, 2'b00, 2'b00, 0, 0, 0, 0, 8'hE3, 3'b111, 32'h1000, 32'hFFFFFFFC, 8, 1, 0};
    vt[6] = '{32'h016C5027, 32'hF0F0F0F0, 32'h0F0F0000, 2'b00, 2'b00, 0, 0, 0, 0, 8'h27, 3'b001, 32'hF0F0F0F0, 32'h0F0F0000, 10, 1, 0};
    vt[7] = '{32'h39CD8001, 32'hDEADBEEF, 0, 2'b00, 2'b00, 0, 0, 0, 0, 8'h26, 3'b001, 32'hDEADBEEF, 32'h00008001, 13, 1, 0};
    vt[8] = '{32'hFC000000, 32'h1, 32'h2, 2'b00, 2'b00, 0, 0, 0, 0, 8'h00, 3'b000, 0, 0, 0, 0, 1};
    vt[9] = '{32'h00842825, 0, 0, 2'b11, 2'b10, 4, 4, 32'h77, 32'h88, 8'h25, 3'b001, 32'h77, 32'h77, 5, 1, 0};

    m = '0; mcnt = '0;
    flush = 0; ex_ready = 1; pc = 32'h400; rd1 = 0; rd2 = 0;
    clear_fwd();

    // Reset held two cycles with a pending hazard on the inputs.
    rst = 1; if_valid = 1; inst = 32'h342200FF;
    fwe[0] = 1; fld[0] = 1; fa[0] = 1;
    cycle();
    chk("rst_ready_hazard", last_ready, 0);
    cycle();
    chk("rst_valid", id_valid, 0);
    chk("rst_cnt", stall_cnt, 0);
    rst = 0;
    clear_fwd();

    for (int i = 0; i < 10; i++) begin
      inst = vt[i].inst; rd1 = vt[i].d1; rd2 = vt[i].d2; pc = 32'h1000 + 4 * i;
      fwe = vt[i].we; fld = vt[i].ld; fa[0] = vt[i].a0; fa[1] = vt[i].a1;
      fd[0] = vt[i].f0; fd[1] = vt[i].f1;
      cycle();
      chk("vec_valid", id_valid, 1);
      chk("vec_aluop", aluop, vt[i].aluop);
      chk("vec_alusel", alusel, vt[i].alusel);
      chk("vec_reg1", reg1, vt[i].e1);
      chk("vec_reg2", reg2, vt[i].e2);
      chk("vec_wd", wd, vt[i].wd);
      chk("vec_wreg", wreg, vt[i].wreg);
      chk("vec_err", inst_err, vt[i].err);
      chk("vec_pc", pc_out, 32'h1000 + 4 * i);
    end

    // Load-use: stall one cycle, then the load moves to an older source.
    clear_fwd();
    inst = 32'h00842825; fwe[0] = 1; fld[0] = 1; fa[0] = 4;
    cnt0 = stall_cnt;
    cycle();
    chk("lu_ready", last_ready, 0);
    chk("lu_bubble", id_valid, 0);
    chk("lu_cnt", stall_cnt, cnt0 + 1'b1);
    clear_fwd();
    fwe[1] = 1; fa[1] = 4; fd[1] = 32'h55;
    cycle();
    chk("lu_ready2", last_ready, 1);
    chk("lu_reg1", reg1, 32'h55);
    chk("lu_reg2", reg2, 32'h55);

    // Backpressure for three cycles, then flush.
    clear_fwd();
    inst = 32'h39CD8001; rd1 = 32'h13572468;
    cycle();
    saved = {id_valid, aluop, alusel, reg1, reg2, wd, wreg, pc_out, inst_err};
    ex_ready = 0;
    for (int i = 0; i < 3; i++) begin
      inst = 32'h00221824 + i; rd1 = $urandom; pc = pc + 4;
      cycle();
      chk("bp_ready", last_ready, 0);
      chk("bp_hold", {id_valid, aluop, alusel, reg1, reg2, wd, wreg, pc_out, inst_err}, saved);
    end
    flush = 1;
    cycle();
    chk("flush_ready", last_ready, 1);
    chk("flush_valid", id_valid, 0);

    // Flush together with a hazard: dropped, not counted.
    ex_ready = 1;
    inst = 32'h00842825; fwe[0] = 1; fld[0] = 1; fa[0] = 4;
    cnt0 = stall_cnt;
    cycle();
    chk("flush_haz_ready", last_ready, 1);
    chk("flush_haz_cnt", stall_cnt, cnt0);
    flush = 0;

    // Saturation over 2^CW+3 hazard cycles.
    for (int i = 0; i < (1 << CW) + 3; i++) cycle();
    chk("sat_cnt", stall_cnt, {CW{1'b1}});

    // Reset in the middle of a stall clears register and counter together.
    rst = 1;
    cycle();
    chk("rst_mid_cnt", stall_cnt, 0);
    chk("rst_mid_valid", id_valid, 0);
    rst = 0;

    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 7))
        0, 1, 2, 3: inst = {6'h00, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                            5'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0) ? 5'd1 : 5'd0,
                            6'h24 + 6'($urandom_range(0, 4))};
        4: inst = {6'h0C + 6'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), 16'($urandom)};
        5: inst = {6'h23, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 16'($urandom)};
        default: inst = $urandom;
      endcase
      for (int i = 0; i < NF; i++) begin
        fwe[i] = 1'($urandom);
        fld[i] = ($urandom_range(0, 3) == 0);
        fa[i] = 5'($urandom_range(0, 3));
        fd[i] = $urandom;
      end
      rd1 = $urandom; rd2 = $urandom; pc = $urandom;
      if_valid = ($urandom_range(0, 4) != 0);
      ex_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 15) == 0);
      rst = ($urandom_range(0, 63) == 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/id_pipe.md
# id_pipe

Parametrised decode stage for the in-order MIPS pipeline, between IF/ID and EX. It decodes the logic-immediate/register subset plus LW and drives regfile read ports. Operands resolve through a configurable number of forwarding sources, and load-use hazards stall the stage. The result is registered into an internal ID/EX register with a valid/ready handshake, flush support and a stall-cycle counter.

## Interface
- DATA_W, 32, register/operand width
- REG_AW, 5, register address width
- NUM_FWD, 2, forwarding sources; index 0 = youngest (EX), higher = older
- CNT_W, 16, stall counter width
- clk  in  1  clock, rising edge
- rst  in  1  reset rst, synchronous, active-high
- flush_i  in  1  discard instruction in ID and ID/EX register
- if_valid_i  in  1  inst_i/pc_i valid
- id_ready_o  out  1  stage accepts inst_i this cycle
- pc_i  in  32  instruction address
- inst_i  in  32  instruction word
- reg1_read_o, reg2_read_o  out  1  regfile read enables (combinational)
- reg1_addr_o, reg2_addr_o  out  REG_AW  rs / rt (combinational)
- reg1_data_i, reg2_data_i  in  DATA_W  regfile read data, same cycle
- fwd_we_i  in  NUM_FWD  source i writes a register
- fwd_is_load_i  in  NUM_FWD  source i is a load (data not yet valid)
- fwd_addr_i  in  NUM_FWD*REG_AW  packed dest addresses, source i at [i*REG_AW +: REG_AW]
- fwd_data_i  in  NUM_FWD*DATA_W  packed write data
- ex_ready_i  in  1  EX accepts ID/EX contents
- id_valid_o  out  1  ID/EX register holds an instruction
- aluop_o  out  8  ; alusel_o  out  3 ; reg1_o, reg2_o  out  DATA_W ; wd_o  out  REG_AW ; wreg_o  out  1
- pc_o  out  32 ; inst_err_o  out  1  illegal instruction
- stall_cnt_o  out  CNT_W  saturating load-use stall cycles

## Operation
- Decode, with op=inst[31:26], sa=inst[10:6], funct=inst[5:0]:
  - SPECIAL (op=0, sa=0), funct 0x24/25/26/27 = AND/OR/XOR/NOR. aluop 0x24/0x25/0x26/0x27, alusel 3'b001, reads rs and rt, wd=rd.
  - ANDI 0x0C, ORI 0x0D, XORI 0x0E: aluop 0x24/0x25/0x26, alusel 001, reads rs, reg2 = zero-extended imm, wd=rt.
  - LUI 0x0F: aluop 0x25, reg1=0 (no read), reg2={imm,16'h0}, wd=rt.
  - LW 0x23: aluop 0xE3, alusel 3'b111, reads rs, reg2 = sign-extended imm, wd=rt.
  - All of the above set wreg=1.
  - Anything else: aluop 0, alusel 0, wreg 0, no reads, inst_err=1.
- Operand resolution per read port, in priority order:
  - addr 0 → 0. No forwarding from address 0; hazards on 0 ignored.
  - Else the lowest index i with fwd_we_i[i] and matching addr wins → fwd_data_i[i].
  - Else → regfile data.
  - Ports not read → the immediate or 0, as listed above.
- Load-use hazard: if_valid_i, and for any read port the winning source has fwd_is_load_i=1.
- id_ready_o = flush_i | (!hazard & (!id_valid_o | ex_ready_i)).
- ID/EX register update, in priority order:
  - rst or flush_i → bubble.
  - Else if !id_valid_o | ex_ready_i: load the decoded instruction when if_valid_i & !hazard, otherwise a bubble.
  - Else hold everything, including captured operands.
- Bubble = id_valid_o 0, all payload 0.
- stall_cnt_o increments each cycle where if_valid_i & hazard & !flush_i, and saturates at all-ones.

## Timing
- Reset: every output register is 0, including id_valid_o, aluop_o, alusel_o, reg1_o, reg2_o, wd_o, wreg_o, pc_o, inst_err_o and stall_cnt_o.
- Decode, forwarding, hazard, read enables/addresses and id_ready_o are combinational on inputs in the same cycle.
- Latency: an accepted instruction appears on the outputs the cycle after acceptance.
- Throughput: 1 instruction/cycle with ex_ready_i high.
- A load-use stall lasts as long as the matching load source is asserted. Normally that is 1 cycle, after which the load moves to a non-load source or mem.
- Simultaneous flush_i and hazard: flush wins, the counter does not increment, and id_ready_o=1 so the instruction is dropped.
- Backpressure (id_valid_o & !ex_ready_i): id_ready_o=0 and outputs stable. A hazard during backpressure does not count unless if_valid_i & hazard hold.
- rst mid-stall: the register clears and the counter clears on the same edge.

## Test plan
- Reset: hold rst 2 cycles with if_valid_i=1 → all outputs 0, id_ready_o reflects hazard logic. First ORI after release appears 1 cycle later.
- ORI $2,$1,0x00FF with reg1_data_i=0x12340000 and no fwd → aluop 0x25, reg1_o 0x12340000, reg2_o 0x000000FF, wd_o 2, wreg_o 1.
- Forwarding priority: AND $3,$1,$2 with fwd0={we,addr 1,0xAAAA}, fwd1={we,addr 1,0xBBBB}, fwd1 addr2=0xCCCC → reg1_o 0xAAAA, reg2_o 0xCCCC. Repeat with rs=0 and fwd addr 0 → reg1_o 0.
- Load-use: fwd0={we,load,addr 4}, inst OR $5,$4,$4 → id_ready_o 0, bubble issued, stall_cnt_o +1. Next cycle load moves to fwd1 with data 0x55 → accepted, reg1_o=reg2_o=0x55.
- Backpressure + flush: ex_ready_i=0 for 3 cycles → outputs held, id_ready_o 0. Then flush_i → id_valid_o 0 next cycle.
- Illegal op 0x3F → inst_err_o 1, wreg_o 0. Force 2^CNT_W+3 hazard cycles → stall_cnt_o saturates at all-ones.
